divrem: RTL and testbench

Sequential unsigned integer divider: accepts an M-bit dividend and an N-bit divisor and produces an M-bit quotient and an N-bit remainder such that dividend = quotient * divisor + remainder, with remainder < divisor. It is the inverse of the multiply-add datapath block. It sits in the same arithmetic benchmark family as a small multi-cycle datapath, using radix-2 restoring division at one quotient bit per cycle. Valid/ready handshakes are used on both input and output.

---
 rtl/divrem_pkg.sv | 16 +
 rtl/divrem_step.sv | 29 ++
 rtl/divrem.sv | 116 +++++++++++
 tb/tb_divrem.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divrem_pkg.sv
// divrem_pkg: shared definitions for the sequential unsigned divider.
//   state_t   - FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   cnt_width - width of the step counter, which must hold the value M
package divrem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/divrem_step.sv
// divrem_step: one radix-2 restoring division step (purely combinational).
// Ports:
//   i_prem    [N-1:0] current partial remainder (its bit N is always zero)
//   i_bit             next dividend bit shifted in at the bottom
//   i_divisor [N-1:0] divisor
//   o_prem    [N-1:0] next partial remainder
//   o_qbit            quotient bit produced by this step
module divrem_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_prem,
  input  logic         i_bit,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_prem,
  output logic         o_qbit
);

  logic [N:0]   w_t;
  logic [N-1:0] w_diff;

  assign w_t = {i_prem, i_bit};

  // When the subtraction is taken the result is below the divisor, so it
  // fits in N bits and the wrap-around of the N-bit subtract is harmless.
  assign w_diff = w_t[N-1:0] - i_divisor;
  assign o_qbit = (w_t >= {1'b0, i_divisor});
  assign o_prem = o_qbit ? w_diff : w_t[N-1:0];

endmodule

// File: rtl/divrem.sv
// divrem: sequential unsigned divider, one quotient bit per cycle.
//   dividend / divisor -> quotient (M bits), remainder (N bits), div0 flag.
// Ports:
//   clk, nreset                       clock, asynchronous active-low reset
//   in_valid, in_ready                operand handshake
//   dividend [M-1:0], divisor [N-1:0] operands, sampled only on accept
//   out_valid, out_ready              result handshake
//   quotient [M-1:0], remainder [N-1:0], div0  result, held while DONE
//   dbg_state [1:0]                   current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE and out_valid is 1 only in DONE; both
// come straight from the state register, so neither depends on any input.
// The result stays stable while out_valid=1 and out_ready=0.
module divrem
  import divrem_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div0,
  output logic [1:0]   dbg_state
);

  localparam int CW = cnt_width(M);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [M-1:0]  r_q;        // dividend bits shift out the top, quotient bits in the bottom
  logic [N-1:0]  r_div;
  logic [N-1:0]  r_prem;     // bit N of the partial remainder is always 0, so it is not stored
  logic [N-1:0]  r_dvd_lo;   // original low dividend bits, the remainder on divide-by-zero
  logic [CW-1:0] r_cnt;
  logic          r_div0;
  logic          w_accept;
  logic [N-1:0]  w_prem_nxt;
  logic          w_qbit;

  divrem_step #(.N(N)) u_step (
    .i_prem    (r_prem),
    .i_bit     (r_q[M-1]),
    .i_divisor (r_div),
    .o_prem    (w_prem_nxt),
    .o_qbit    (w_qbit)
  );

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        // A count of 1 marks the final step.
        if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_q      <= '0;
      r_div    <= '0;
      r_prem   <= '0;
      r_dvd_lo <= '0;
      r_cnt    <= '0;
      r_div0   <= 1'b0;
    end else if (w_accept) begin
      r_q      <= dividend;
      r_div    <= divisor;
      r_prem   <= '0;
      r_dvd_lo <= dividend[N-1:0];
      r_cnt    <= CW'(M);
      r_div0   <= (divisor == '0);
    end else if (r_state == ST_BUSY) begin
      // With a zero divisor every compare succeeds, giving an all-ones quotient.
      r_prem <= w_prem_nxt;
      r_q    <= (r_q << 1) | M'(w_qbit);
      r_cnt  <= r_cnt - CW'(1);
    end
  end

  assign quotient  = r_q;
  assign remainder = r_div0 ? r_dvd_lo : r_prem;
  assign div0      = r_div0;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_divrem.sv
module tb_divrem;
  import divrem_pkg::*;

  localparam int N  = 8;
  localparam int M  = 8;
  localparam int M2 = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset;

  // DUT with N=M=8
  logic         in_valid, in_ready, out_valid, out_ready, div0;
  logic [M-1:0] dividend, quotient;
  logic [N-1:0] divisor, remainder;
  logic [1:0]   dbg_state;

  // DUT with N=8, M=16
  logic          w16_in_valid, w16_in_ready, w16_out_valid, w16_out_ready, w16_div0;
  logic [M2-1:0] w16_dividend, w16_quotient;
  logic [N-1:0]  w16_divisor, w16_remainder;
  logic [1:0]    w16_dbg_state;

  divrem #(.N(N), .M(M)) u_dut (
    .clk(clk), .nreset(nreset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div0(div0),
    .dbg_state(dbg_state)
  );

  divrem #(.N(N), .M(M2)) u_dut16 (
    .clk(clk), .nreset(nreset),
    .in_valid(w16_in_valid), .in_ready(w16_in_ready),
    .dividend(w16_dividend), .divisor(w16_divisor),
    .out_valid(w16_out_valid), .out_ready(w16_out_ready),
    .quotient(w16_quotient), .remainder(w16_remainder), .div0(w16_div0),
    .dbg_state(w16_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones quotient
  // and the low N dividend bits as remainder.
  function automatic void ref_div(input int unsigned a, input int unsigned d,
                                  input int mbits,
                                  output int unsigned q, output int unsigned r,
                                  output bit z);
    if (d == 0) begin
      q = (32'd1 << mbits) - 1;
      r = a & ((32'd1 << N) - 1);
      z = 1'b1;
    end else begin
      q = a / d;
      r = a % d;
      z = 1'b0;
    end
  endfunction

  typedef struct {
    logic [M-1:0] a;
    logic [N-1:0] d;
    logic [M-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec8_t;

  typedef struct {
    logic [M2-1:0] a;
    logic [N-1:0]  d;
    logic [M2-1:0] q;
    logic [N-1:0]  r;
    logic          z;
  } vec16_t;

  // ---------------- driver tasks ----------------
  // Runs one operation on the 8/8 DUT. 'hold' cycles of backpressure are
  // applied after out_valid, with junk in_valid pulses that must be ignored.
  task automatic op8(input logic [M-1:0] a, input logic [N-1:0] d, input int hold,
                     output logic [M-1:0] q, output logic [N-1:0] r,
                     output logic z, output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; dividend = a; divisor = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; dividend = M'($urandom); divisor = N'($urandom);
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 4 * M) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    q = quotient; r = remainder; z = div0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; dividend = M'($urandom); divisor = N'($urandom);
      @(posedge clk); @(negedge clk);
      chk("hold_quotient", quotient, q);
      chk("hold_remainder", remainder, r);
      chk("hold_div0", div0, z);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_consume", out_valid, 0);
    chk("in_ready_after_consume", in_ready, 1);
  endtask

  task automatic op16(input logic [M2-1:0] a, input logic [N-1:0] d,
                      output logic [M2-1:0] q, output logic [N-1:0] r,
                      output logic z, output int lat);
    @(negedge clk);
    w16_in_valid = 1'b1; w16_dividend = a; w16_divisor = d;
    @(posedge clk);
    @(negedge clk);
    w16_in_valid = 1'b0; w16_dividend = M2'($urandom); w16_divisor = N'($urandom);
    lat = 0;
    while (!w16_out_valid && lat < 4 * M2) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    q = w16_quotient; r = w16_remainder; z = w16_div0;
    w16_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    w16_out_ready = 1'b0;
    chk("w16_in_ready_after_consume", w16_in_ready, 1);
  endtask

  // ---------------- test sequence ----------------
  vec8_t  tbl8[9];
  vec16_t tbl16[5];

  initial begin
    logic [M-1:0]  q8;
    logic [M2-1:0] q16;
    logic [N-1:0]  r8;
    logic          z8;
    int            lat;
    int unsigned   eq, er, a, d;
    bit            ez;

    tbl8[0] = '{a: 8'd200, d: 8'd7,   q: 8'd28,  r: 8'd4,   z: 1'b0};
    tbl8[1] = '{a: 8'd13,  d: 8'd0,   q: 8'd255, r: 8'd13,  z: 1'b1};
    tbl8[2] = '{a: 8'd100, d: 8'd10,  q: 8'd10,  r: 8'd0,   z: 1'b0};
    tbl8[3] = '{a: 8'd0,   d: 8'd5,   q: 8'd0,   r: 8'd0,   z: 1'b0};
    tbl8[4] = '{a: 8'd255, d: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
    tbl8[5] = '{a: 8'd255, d: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
    tbl8[6] = '{a: 8'd5,   d: 8'd9,   q: 8'd0,   r: 8'd5,   z: 1'b0};
    tbl8[7] = '{a: 8'd254, d: 8'd255, q: 8'd0,   r: 8'd254, z: 1'b0};
    tbl8[8] = '{a: 8'd128, d: 8'd3,   q: 8'd42,  r: 8'd2,   z: 1'b0};

    tbl16[0] = '{a: 16'd65535, d: 8'd255, q: 16'd257,   r: 8'd0,  z: 1'b0};
    tbl16[1] = '{a: 16'd5,     d: 8'd9,   q: 16'd0,     r: 8'd5,  z: 1'b0};
    tbl16[2] = '{a: 16'd300,   d: 8'd0,   q: 16'd65535, r: 8'd44, z: 1'b1};
    tbl16[3] = '{a: 16'd1000,  d: 8'd7,   q: 16'd142,   r: 8'd6,  z: 1'b0};
    tbl16[4] = '{a: 16'd0,     d: 8'd1,   q: 16'd0,     r: 8'd0,  z: 1'b0};

    nreset = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    w16_in_valid = 1'b0; w16_out_ready = 1'b0; w16_dividend = '0; w16_divisor = '0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_div0", div0, 0);
    chk("reset_state", dbg_state, 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    nreset = 1'b1;

    // table-driven vectors, N=M=8
    for (int i = 0; i < 9; i++) begin
      op8(tbl8[i].a, tbl8[i].d, 0, q8, r8, z8, lat);
      chk("tbl8_latency", lat, M);
      chk("tbl8_quotient", q8, tbl8[i].q);
      chk("tbl8_remainder", r8, tbl8[i].r);
      chk("tbl8_div0", z8, tbl8[i].z);
    end

    // table-driven vectors, N=8 M=16
    for (int i = 0; i < 5; i++) begin
      op16(tbl16[i].a, tbl16[i].d, q16, r8, z8, lat);
      chk("tbl16_latency", lat, M2);
      chk("tbl16_quotient", q16, tbl16[i].q);
      chk("tbl16_remainder", r8, tbl16[i].r);
      chk("tbl16_div0", z8, tbl16[i].z);
    end

    // backpressure: 5 stalled cycles with ignored in_valid pulses
    op8(8'd77, 8'd6, 5, q8, r8, z8, lat);
    chk("bp_quotient", q8, 12);
    chk("bp_remainder", r8, 5);
    op8(8'd9, 8'd4, 0, q8, r8, z8, lat);
    chk("bp_next_quotient", q8, 2);
    chk("bp_next_remainder", r8, 1);

    // reset in the middle of an operation (after step 3 of 8)
    @(negedge clk);
    in_valid = 1'b1; dividend = 8'd50; divisor = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_div0", div0, 0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (M + 2) begin
      @(negedge clk);
      chk("midrst_no_spurious", out_valid, 0);
    end
    op8(8'd100, 8'd10, 0, q8, r8, z8, lat);
    chk("postrst_quotient", q8, 10);
    chk("postrst_remainder", r8, 0);
    chk("postrst_latency", lat, M);

    // randomized sweep, N=M=8
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      case ($urandom_range(0, 9))
        0: d = 1;
        1: d = 255;
        2: a = 0;
        3: d = 0;
        4: a = 255;
        default: ;
      endcase
      op8(M'(a), N'(d), (i % 50 == 0) ? 2 : 0, q8, r8, z8, lat);
      ref_div(a, d, M, eq, er, ez);
      chk("rnd8_latency", lat, M);
      chk("rnd8_quotient", q8, eq);
      chk("rnd8_remainder", r8, er);
      chk("rnd8_div0", z8, ez);
      if (d != 0) begin
        chk("rnd8_identity", 32'(q8) * d + 32'(r8), a);
        chk("rnd8_rem_lt_div", 32'(r8 < d), 1);
      end
    end

    // randomized sweep, N=8 M=16
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, 65535);
      d = $urandom_range(0, 255);
      case ($urandom_range(0, 7))
        0: d = 1;
        1: d = 255;
        2: a = 0;
        3: d = 0;
        default: ;
      endcase
      op16(M2'(a), N'(d), q16, r8, z8, lat);
      ref_div(a, d, M2, eq, er, ez);
      chk("rnd16_latency", lat, M2);
      chk("rnd16_quotient", q16, eq);
      chk("rnd16_remainder", r8, er);
      chk("rnd16_div0", z8, ez);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
